// File: rtl/student_fir_sched.sv
// -----------------------------------------------------------------------------
// student_fir_sched
//
// Scheduler for a filter built from NUM_FIR cascaded FIR segments. Each
// accepted sample is launched to every segment at once. Segment 0 receives the
// new sample. Segment k (k >= 1) receives the oldest sample that segment k-1
// shifted out on the previous round. The scheduler then waits for every
// segment's done pulse and captures each partial sum and shift-out value. It
// adds the partial sums serially, one per cycle, and presents the total on y_o
// with a one-cycle y_valid_o pulse.
//
// States: IDLE -> LAUNCH -> WAIT -> SUM -> OUT -> IDLE.
//   WAIT also returns to IDLE (setting timeout_err_o) when a segment fails
//   to finish within TIMEOUT_CYCLES cycles.
//
// Ports
//   clk_i               clock; all logic on the rising edge
//   rst_i               synchronous, active-high reset
//   sample_valid_i      one-cycle pulse, new sample on sample_i
//   sample_i            new sample (DATA_SIZE)
//   sample_ready_o      high only in IDLE
//   fir_valid_strobe_o  per-segment start strobe (NUM_FIR)
//   fir_sample_o        per-segment sample, segment k in slice k
//   fir_done_i          per-segment compute-finished pulse (NUM_FIR)
//   fir_shift_i         per-segment oldest sample shifted out
//   fir_y_i             per-segment partial sum (DATA_SIZE_FIR_OUT each)
//   y_o                 final sum (SUM_WIDTH), held between results
//   y_valid_o           one-cycle pulse, y_o valid
//   busy_o              high in every state except IDLE
//   overrun_err_o       sticky, a sample arrived outside IDLE and was dropped
//   timeout_err_o       sticky, a segment failed to finish in time
//
// Build option
//   STUDENT_FIR_SCHED_SAT_EN  when defined, the accumulator saturates at
//                             2^SUM_WIDTH-1 instead of wrapping.
// -----------------------------------------------------------------------------
module student_fir_sched #(
  parameter int NUM_FIR           = 4,
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int SUM_WIDTH         = 36,
  parameter int TIMEOUT_CYCLES    = 4095
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   sample_valid_i,
  input  logic [DATA_SIZE-1:0]                   sample_i,
  output logic                                   sample_ready_o,
  output logic [NUM_FIR-1:0]                     fir_valid_strobe_o,
  output logic [NUM_FIR*DATA_SIZE-1:0]           fir_sample_o,
  input  logic [NUM_FIR-1:0]                     fir_done_i,
  input  logic [NUM_FIR*DATA_SIZE-1:0]           fir_shift_i,
  input  logic [NUM_FIR*DATA_SIZE_FIR_OUT-1:0]   fir_y_i,
  output logic [SUM_WIDTH-1:0]                   y_o,
  output logic                                   y_valid_o,
  output logic                                   busy_o,
  output logic                                   overrun_err_o,
  output logic                                   timeout_err_o
);

  localparam int IDX_W = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef STUDENT_FIR_SCHED_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SUM,
    ST_OUT
  } state_t;

  // One extra bit above the sum so the carry out is visible for saturation.
  typedef logic [SUM_WIDTH:0] ext_t;

  state_t                       state;
  logic [NUM_FIR-1:0]           done_mask;
  logic [CNT_W-1:0]             wait_cnt;
  logic [IDX_W-1:0]             sum_idx;
  logic [SUM_WIDTH-1:0]         acc;
  logic [DATA_SIZE_FIR_OUT-1:0] y_cap     [NUM_FIR];
  logic [DATA_SIZE-1:0]         shift_cap [NUM_FIR];

  logic [NUM_FIR-1:0]           strobe_q;
  logic [NUM_FIR*DATA_SIZE-1:0] sample_q;
  logic [SUM_WIDTH-1:0]         y_q;
  logic                         y_valid_q;
  logic                         overrun_q;
  logic                         timeout_q;

  logic [NUM_FIR-1:0]           done_new;
  logic [NUM_FIR-1:0]           mask_next;
  ext_t                         sum_wide;
  logic [SUM_WIDTH-1:0]         sum_next;

  // NOTE: every signal driven here gets a value on every pass through the
  // block, so no latch is inferred.
  always_comb begin
    // Only the first done pulse of a segment in a round is captured; repeats
    // are masked off.
    done_new  = fir_done_i & ~done_mask;
    // Includes this cycle's pulses, so WAIT exits on the same edge that
    // completes the set.
    mask_next = done_mask | fir_done_i;
    // Both operands are zero-extended. The sum is below 2^(SUM_WIDTH+1), so
    // the top bit is exactly the wrap indication.
    sum_wide  = {1'b0, acc} + ext_t'(y_cap[sum_idx]);
    sum_next  = (SAT_EN && sum_wide[SUM_WIDTH]) ? '1 : sum_wide[SUM_WIDTH-1:0];
  end

  // NOTE: all state below uses non-blocking assignments. Every register then
  // updates from values sampled before the edge, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      done_mask <= '0;
      wait_cnt  <= '0;
      sum_idx   <= '0;
      acc       <= '0;
      // NOTE: the capture arrays are reset explicitly. The first sample after
      // reset must see all-zero history in slices 1..NUM_FIR-1, so the
      // arrays cannot be left to power-up values.
      for (int k = 0; k < NUM_FIR; k++) begin
        y_cap[k]     <= '0;
        shift_cap[k] <= '0;
      end
      strobe_q  <= '0;
      sample_q  <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // Pulse-type outputs default low and are raised only on their cycle.
      strobe_q  <= '0;
      y_valid_q <= 1'b0;

      // A sample arriving while busy, including during OUT, is lost.
      if (sample_valid_i && (state != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (sample_valid_i) begin
            sample_q[DATA_SIZE-1:0] <= sample_i;
            // Segment k continues the delay line where segment k-1 ended.
            for (int k = 1; k < NUM_FIR; k++) begin
              sample_q[k*DATA_SIZE +: DATA_SIZE] <= shift_cap[k-1];
            end
            // The strobe is raised here so it is high during the LAUNCH cycle.
            strobe_q <= '1;
            state    <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          done_mask <= '0;
          wait_cnt  <= '0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          done_mask <= mask_next;
          for (int k = 0; k < NUM_FIR; k++) begin
            if (done_new[k]) begin
              y_cap[k]     <= fir_y_i[k*DATA_SIZE_FIR_OUT +: DATA_SIZE_FIR_OUT];
              shift_cap[k] <= fir_shift_i[k*DATA_SIZE +: DATA_SIZE];
            end
          end
          // Completion wins over a timeout that would fire on the same cycle.
          if (&mask_next) begin
            acc     <= '0;
            sum_idx <= '0;
            state   <= ST_SUM;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th WAIT cycle. Abandon the round.
            // Captured history is kept, so the next sample still launches.
            timeout_q <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_SUM: begin
          acc <= sum_next;
          if (sum_idx == IDX_W'(NUM_FIR - 1)) begin
            // The result register is loaded from the final sum, so y_o is
            // valid in the OUT cycle and held afterwards.
            y_q       <= sum_next;
            y_valid_q <= 1'b1;
            state     <= ST_OUT;
          end else begin
            sum_idx <= sum_idx + IDX_W'(1);
          end
        end

        ST_OUT: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sample_ready_o     = (state == ST_IDLE);
  assign busy_o             = (state != ST_IDLE);
  assign fir_valid_strobe_o = strobe_q;
  assign fir_sample_o       = sample_q;
  assign y_o                = y_q;
  assign y_valid_o          = y_valid_q;
  assign overrun_err_o      = overrun_q;
  assign timeout_err_o      = timeout_q;

endmodule

// File: tb/tb_student_fir_sched.sv
// -----------------------------------------------------------------------------
// tb_student_fir_sched
//
// Directed bench for student_fir_sched using the default parameters
// (NUM_FIR=4, DATA_SIZE=16, DATA_SIZE_FIR_OUT=32, SUM_WIDTH=36,
// TIMEOUT_CYCLES=4095). The bench plays the role of the four FIR segments.
// Inputs are driven 1 ns after each rising edge; outputs are observed at the
// same point.
// -----------------------------------------------------------------------------
module tb_student_fir_sched;

  logic         clk;
  logic         rst;
  logic         sample_valid;
  logic [15:0]  sample;
  logic         sample_ready;
  logic [3:0]   fir_valid_strobe;
  logic [63:0]  fir_sample;
  logic [3:0]   fir_done;
  logic [63:0]  fir_shift;
  logic [127:0] fir_y;
  logic [35:0]  y;
  logic         y_valid;
  logic         busy;
  logic         overrun_err;
  logic         timeout_err;

  int checks   = 0;
  int failures = 0;
  int yv_count = 0;

  student_fir_sched dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .sample_valid_i     (sample_valid),
    .sample_i           (sample),
    .sample_ready_o     (sample_ready),
    .fir_valid_strobe_o (fir_valid_strobe),
    .fir_sample_o       (fir_sample),
    .fir_done_i         (fir_done),
    .fir_shift_i        (fir_shift),
    .fir_y_i            (fir_y),
    .y_o                (y),
    .y_valid_o          (y_valid),
    .busy_o             (busy),
    .overrun_err_o      (overrun_err),
    .timeout_err_o      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every y_valid_o pulse, so aborted rounds can be shown to
  // produce none.
  always @(negedge clk) begin
    if (y_valid === 1'b1) yv_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present a sample for one cycle. Returns in the cycle after acceptance,
  // which is the LAUNCH cycle.
  task automatic send_sample(input logic [15:0] val);
    sample_valid = 1'b1;
    sample       = val;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] mask);
    fir_done = mask;
    step();
    fir_done = '0;
  endtask

  // Call this right after the edge that sampled the last done, i.e. in
  // cycle D+1. Returns n where y_valid is first seen in cycle D+n; returns
  // 0 when no pulse appears within 20 cycles. On a hit the bench is left
  // in the OUT cycle.
  task automatic wait_y_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (y_valid === 1'b1) begin
        lat = n;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (y !== 36'h0) begin failures++; $display("FAIL reset_y: got %0h expected 0", y); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid: got %0b expected 0", y_valid); end
    checks++; if (fir_valid_strobe !== 4'h0) begin failures++; $display("FAIL reset_strobe: got %0h expected 0", fir_valid_strobe); end
    checks++; if (fir_sample !== 64'h0) begin failures++; $display("FAIL reset_sample: got %0h expected 0", fir_sample); end
    checks++; if (busy !== 1'b0 || sample_ready !== 1'b1) begin failures++; $display("FAIL reset_busy_ready: got busy=%0b ready=%0b expected 0/1", busy, sample_ready); end
    checks++; if (overrun_err !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_errs: got ovr=%0b to=%0b expected 0/0", overrun_err, timeout_err); end
  endtask

  task automatic test_basic();
    int lat;
    fir_y     = {32'd4, 32'd3, 32'd2, 32'd1};
    fir_shift = {16'hD, 16'hC, 16'hB, 16'hA};
    send_sample(16'h0010);
    checks++; if (fir_valid_strobe !== 4'hF) begin failures++; $display("FAIL basic_strobe_on: got %0h expected f", fir_valid_strobe); end
    checks++; if (fir_sample !== 64'h0000_0000_0000_0010) begin failures++; $display("FAIL basic_slices: got %0h expected 10", fir_sample); end
    checks++; if (busy !== 1'b1 || sample_ready !== 1'b0) begin failures++; $display("FAIL basic_busy: got busy=%0b ready=%0b expected 1/0", busy, sample_ready); end
    step();
    checks++; if (fir_valid_strobe !== 4'h0) begin failures++; $display("FAIL basic_strobe_off: got %0h expected 0", fir_valid_strobe); end
    pulse_done(4'hF);
    wait_y_valid(lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    checks++; if (y !== 36'd10) begin failures++; $display("FAIL basic_y: got %0h expected a", y); end
    step();
    checks++; if (y_valid !== 1'b0 || y !== 36'd10 || sample_ready !== 1'b1) begin failures++; $display("FAIL basic_hold: got yv=%0b y=%0h ready=%0b expected 0/a/1", y_valid, y, sample_ready); end
  endtask

  task automatic test_stagger();
    int lat;
    // A done pulse in IDLE must not capture anything.
    fir_shift = {16'hEE, 16'hEE, 16'hEE, 16'hEE};
    fir_y     = {32'd99, 32'd99, 32'd99, 32'd99};
    pulse_done(4'hF);
    send_sample(16'h0020);
    checks++; if (fir_sample !== {16'hC, 16'hB, 16'hA, 16'h20}) begin failures++; $display("FAIL stagger_slices: got %0h expected c000b000a0020", fir_sample); end
    step();
    fir_y     = {32'd8, 32'd7, 32'd6, 32'd5};
    fir_shift = {16'h44, 16'h33, 16'h22, 16'h11};
    pulse_done(4'b0001);             // c1
    fir_y[31:0] = 32'd100;           // a repeat pulse from segment 0 must be ignored
    pulse_done(4'b0001);             // c2
    step();                          // c3
    pulse_done(4'b0010);             // c4
    repeat (6) step();               // c5..c10
    pulse_done(4'b0100);             // c11
    step();                          // c12
    pulse_done(4'b1000);             // c13 = D
    wait_y_valid(lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL stagger_latency: got %0d expected 5", lat); end
    checks++; if (y !== 36'd26) begin failures++; $display("FAIL stagger_y: got %0h expected 1a", y); end
    step();
  endtask

  task automatic test_overrun_out();
    int lat;
    send_sample(16'h0030);
    checks++; if (fir_sample !== {16'h33, 16'h22, 16'h11, 16'h30}) begin failures++; $display("FAIL ovr_out_slices: got %0h expected 33002200110030", fir_sample); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_out_pre: got %0b expected 0", overrun_err); end
    step();
    fir_y     = {32'd40, 32'd30, 32'd20, 32'd10};
    fir_shift = {16'h4, 16'h3, 16'h2, 16'h1};
    pulse_done(4'hF);
    wait_y_valid(lat);
    checks++; if (lat != 5 || y !== 36'd100) begin failures++; $display("FAIL ovr_out_result: got lat=%0d y=%0h expected 5/64", lat, y); end
    sample_valid = 1'b1;             // arrives during OUT, must be dropped
    sample       = 16'h0BEE;
    step();
    sample_valid = 1'b0;
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_out_flag: got %0b expected 1", overrun_err); end
    checks++; if (fir_valid_strobe !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL ovr_out_launch: got strobe=%0h busy=%0b expected 0/0", fir_valid_strobe, busy); end
    step();
    checks++; if (busy !== 1'b0 || fir_sample !== {16'h33, 16'h22, 16'h11, 16'h30} || y !== 36'd100) begin failures++; $display("FAIL ovr_out_hold: got busy=%0b smp=%0h y=%0h expected 0/33002200110030/64", busy, fir_sample, y); end
  endtask

  task automatic test_overrun_wait();
    int lat;
    do_reset();
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_clear_by_reset: got %0b expected 0", overrun_err); end
    send_sample(16'h0040);
    step();
    sample_valid = 1'b1;             // arrives during WAIT, must be dropped
    sample       = 16'h0BAD;
    step();
    sample_valid = 1'b0;
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_wait_flag: got %0b expected 1", overrun_err); end
    checks++; if (fir_sample !== 64'h40 || fir_valid_strobe !== 4'h0) begin failures++; $display("FAIL ovr_wait_launch: got smp=%0h strobe=%0h expected 40/0", fir_sample, fir_valid_strobe); end
    fir_y     = {32'h400, 32'h300, 32'h200, 32'h100};
    fir_shift = {16'h8, 16'h7, 16'h6, 16'h5};
    pulse_done(4'hF);
    wait_y_valid(lat);
    checks++; if (lat != 5 || y !== 36'hA00) begin failures++; $display("FAIL ovr_wait_result: got lat=%0d y=%0h expected 5/a00", lat, y); end
    step();
    step();
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %0b expected 1", overrun_err); end
  endtask

  task automatic test_timeout();
    int lat;
    int yv_before;
    send_sample(16'h0050);
    checks++; if (fir_sample !== {16'h7, 16'h6, 16'h5, 16'h50}) begin failures++; $display("FAIL to_slices: got %0h expected 7000600050050", fir_sample); end
    step();                          // WAIT cycle 1
    yv_before = yv_count;
    fir_y     = {32'd1, 32'd1, 32'd1, 32'd1};
    fir_shift = {16'h64, 16'h63, 16'h62, 16'h61};
    pulse_done(4'b1011);             // segment 2 never finishes
    repeat (4093) step();            // now in WAIT cycle 4095
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_early: got to=%0b busy=%0b expected 0/1", timeout_err, busy); end
    step();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || sample_ready !== 1'b1) begin failures++; $display("FAIL to_fire: got to=%0b busy=%0b ready=%0b expected 1/0/1", timeout_err, busy, sample_ready); end
    checks++; if (yv_count != yv_before) begin failures++; $display("FAIL to_no_y_valid: got %0d pulses expected %0d", yv_count, yv_before); end
    send_sample(16'h0070);
    checks++; if (fir_valid_strobe !== 4'hF || fir_sample !== {16'h7, 16'h62, 16'h61, 16'h70}) begin failures++; $display("FAIL to_next_accept: got strobe=%0h smp=%0h expected f/7006200610070", fir_valid_strobe, fir_sample); end
    step();
    pulse_done(4'hF);
    wait_y_valid(lat);
    checks++; if (lat != 5 || y !== 36'd4) begin failures++; $display("FAIL to_next_result: got lat=%0d y=%0h expected 5/4", lat, y); end
    step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %0b expected 1", timeout_err); end
  endtask

  task automatic test_max_sum();
    int lat;
    fir_y     = {4{32'hFFFF_FFFF}};
    fir_shift = '0;
    for (int r = 0; r < 16; r++) begin
      send_sample(16'(r));
      step();
      pulse_done(4'hF);
      wait_y_valid(lat);
      checks++;
      if (lat != 5 || y !== 36'h3_FFFF_FFFC) begin
        failures++;
        $display("FAIL max_sum_round%0d: got lat=%0d y=%0h expected 5/3fffffffc", r, lat, y);
      end
      step();
    end
  endtask

  task automatic test_reset_in_sum();
    int yv_before;
    fir_y = {32'd7, 32'd7, 32'd7, 32'd7};
    send_sample(16'h0099);
    step();
    pulse_done(4'hF);                // now in SUM cycle 1
    step();                          // SUM cycle 2
    yv_before = yv_count;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (y !== 36'h0 || y_valid !== 1'b0) begin failures++; $display("FAIL rst_sum_y: got y=%0h yv=%0b expected 0/0", y, y_valid); end
    checks++; if (fir_valid_strobe !== 4'h0 || fir_sample !== 64'h0) begin failures++; $display("FAIL rst_sum_fir: got strobe=%0h smp=%0h expected 0/0", fir_valid_strobe, fir_sample); end
    checks++; if (busy !== 1'b0 || sample_ready !== 1'b1 || overrun_err !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_sum_status: got busy=%0b ready=%0b ovr=%0b to=%0b expected 0/1/0/0", busy, sample_ready, overrun_err, timeout_err); end
    repeat (8) step();
    checks++; if (yv_count != yv_before) begin failures++; $display("FAIL rst_sum_no_y_valid: got %0d pulses expected %0d", yv_count, yv_before); end
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    fir_done     = '0;
    fir_shift    = '0;
    fir_y        = '0;

    test_reset();
    test_basic();
    test_stagger();
    test_overrun_out();
    test_overrun_wait();
    test_timeout();
    test_max_sum();
    test_reset_in_sum();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/student_fir_sched.md
STUDENT_FIR_SCHED -- requirements
Module: student_fir_sched

Interface
REQ-001 SHALL have parameter NUM_FIR, default 4, number of cascaded FIR segments (2..16).
REQ-002 SHALL have parameter DATA_SIZE, default 16, sample width.
REQ-003 SHALL have parameter DATA_SIZE_FIR_OUT, default 32, per-segment partial-sum width.
REQ-004 SHALL have parameter SUM_WIDTH, default 36, final sum width (>= DATA_SIZE_FIR_OUT).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4095, maximum cycles spent in WAIT.
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 sample_valid_i  input  1  one-cycle pulse; new sample available.
REQ-009 sample_i  input  DATA_SIZE  new sample.
REQ-010 sample_ready_o  output  1  high only in IDLE.
REQ-011 fir_valid_strobe_o  output  NUM_FIR  per-segment start strobe.
REQ-012 fir_sample_o  output  NUM_FIR*DATA_SIZE  per-segment sample; segment k in slice k.
REQ-013 fir_done_i  input  NUM_FIR  per-segment compute-finished pulse.
REQ-014 fir_shift_i  input  NUM_FIR*DATA_SIZE  per-segment oldest sample shifted out.
REQ-015 fir_y_i  input  NUM_FIR*DATA_SIZE_FIR_OUT  per-segment partial sum.
REQ-016 y_o  output  SUM_WIDTH  final filter output.
REQ-017 y_valid_o  output  1  one-cycle pulse; y_o valid.
REQ-018 busy_o  output  1  high in every state except IDLE.
REQ-019 overrun_err_o  output  1  sticky; sample dropped.
REQ-020 timeout_err_o  output  1  sticky; segment failed to finish.

Function
REQ-021 SHALL implement states IDLE, LAUNCH, WAIT, SUM, OUT.
REQ-022 IDLE: sample_valid_i=1 SHALL register sample_i into fir_sample_o slice 0, load slice k (k>=1) from captured shift[k-1], and go to LAUNCH.
REQ-023 LAUNCH: fir_valid_strobe_o SHALL be all ones for exactly one cycle, then zero; clear done mask and wait counter; go to WAIT.
REQ-024 WAIT: fir_done_i[k]=1 SHALL set done mask bit k and capture fir_y_i slice k and fir_shift_i slice k in the same edge.
REQ-025 Done pulses for bits already set, and done pulses in any state other than WAIT, SHALL be ignored.
REQ-026 WAIT SHALL go to SUM on the edge where the mask, including done pulses in that cycle, becomes all ones.
REQ-027 WAIT counter reaching TIMEOUT_CYCLES SHALL set timeout_err_o, return to IDLE without y_valid_o, and leave the captured shift registers unchanged.
REQ-028 SUM SHALL clear the accumulator on entry and add one captured partial sum per cycle (index 0..NUM_FIR-1); operands are zero-extended and the add wraps modulo 2^SUM_WIDTH.
REQ-029 After index NUM_FIR-1, SHALL go to OUT; OUT SHALL drive y_o=accumulator, y_valid_o=1 for one cycle, then go to IDLE.
REQ-030 Latency: last done sampled at cycle D -> SUM cycles D+1..D+NUM_FIR, y_valid_o high at D+NUM_FIR+1.
REQ-031 sample_valid_i in any state other than IDLE, including OUT, SHALL be dropped and SHALL set overrun_err_o.
REQ-032 y_o SHALL hold its value between y_valid_o pulses.
REQ-033 fir_sample_o SHALL hold its value until the next accepted sample.

Reset
REQ-034 rst_i SHALL force IDLE, clear mask, counters and accumulator, and zero captured shift and y registers.
REQ-035 Reset values: y_o=0, y_valid_o=0, fir_valid_strobe_o=0, fir_sample_o=0, busy_o=0, sample_ready_o=1 from the first cycle after reset, overrun_err_o=0, timeout_err_o=0.
REQ-036 rst_i asserted mid-operation SHALL abort the operation with no y_valid_o pulse.
REQ-037 Sticky error flags SHALL be cleared only by rst_i.

Configuration
REQ-038 Macro STUDENT_FIR_SCHED_SAT_EN, when defined, SHALL saturate the accumulator at 2^SUM_WIDTH-1 instead of wrapping.
REQ-039 When STUDENT_FIR_SCHED_SAT_EN is undefined, the accumulator SHALL wrap per REQ-028; all other behaviour is identical.

Verification (NUM_FIR=4, SUM_WIDTH=36)
REQ-040 Reset, then sample 0x0010 -> strobe 4'b1111 one cycle after acceptance, slice0=0x0010, slices1-3=0; done pulses with y={1,2,3,4} -> y_o=10, y_valid_o one cycle.
REQ-041 Second sample with captured shifts {0xA,0xB,0xC,x} -> slices1-3=0xA,0xB,0xC; done pulses staggered 0,3,7,2 cycles apart -> y_valid_o exactly 5 cycles after the last done.
REQ-042 sample_valid_i during WAIT and during OUT -> sample not launched, overrun_err_o=1 until reset, result unaffected.
REQ-043 Segment 2 never asserts done -> timeout_err_o=1 after 4095 WAIT cycles, return to IDLE with no y_valid_o, next sample accepted.
REQ-044 All y=0xFFFFFFFF over 16 consecutive rounds -> y_o=0x3FFFFFFFC (no wrap); with STUDENT_FIR_SCHED_SAT_EN and SUM_WIDTH=33 -> y_o=0x1FFFFFFFF.
REQ-045 rst_i pulsed during SUM -> no y_valid_o, all outputs at reset values next cycle.
